// File: rtl/mr_lsu_pkg.sv
// Shared types and constants for the mr-soc load/store unit.
// Memop/size encodings match what the execute stage drives.
package mr_lsu_pkg;

  localparam int XLEN        = 32;
  localparam int REGSEL_BITS = 5;

  typedef enum logic [1:0] {
    MEMOP_NONE  = 2'd0,
    MEMOP_LOAD  = 2'd1,
    MEMOP_STORE = 2'd2
  } e_memops;

  typedef enum logic [1:0] {
    MEMSZ_B = 2'd0,
    MEMSZ_H = 2'd1,
    MEMSZ_W = 2'd2
  } e_memsz;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } e_lsu_state;

endpackage

// File: rtl/mr_lsu_lanes.sv
// Byte-lane logic for the LSU: store strobe/data steering, load shift and
// extend, and alignment check. Purely combinational.
module mr_lsu_lanes
  import mr_lsu_pkg::*;
(
  input  logic [1:0]      st_off,
  input  e_memsz          st_size,
  input  logic [XLEN-1:0] st_payload,
  output logic [3:0]      st_wstrb,
  output logic [XLEN-1:0] st_wdata,
  output logic            misaligned,
  input  logic [1:0]      ld_off,
  input  e_memsz          ld_size,
  input  logic            ld_signed,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  // NOTE: every output gets a default at the top of the block so that no
  // path through the case leaves a value unassigned, which would infer a latch.
  always_comb begin
    st_wstrb   = 4'b1111;
    st_wdata   = st_payload;
    misaligned = 1'b0;
    ld_data    = shifted;
    case (st_size)
      MEMSZ_B: begin
        st_wstrb = 4'b0001 << st_off;
        st_wdata = {4{st_payload[7:0]}};
      end
      MEMSZ_H: begin
        st_wstrb   = 4'b0011 << st_off;
        st_wdata   = {2{st_payload[15:0]}};
        misaligned = st_off[0];
      end
      default: misaligned = (st_off != 2'b00);
    endcase
    case (ld_size)
      MEMSZ_B: ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
      MEMSZ_H: ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mr_lsu.sv
// Load/store stage: accepts ops from execute, runs one req/ack data access
// per aligned load/store, and hands results to writeback.
module mr_lsu
  import mr_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ls_valid,
  output logic                   ls_ready,
  input  logic [XLEN-1:0]        ls_dest,
  input  logic [REGSEL_BITS-1:0] ls_dest_reg,
  input  e_memops                ls_memop,
  input  e_memsz                 ls_size,
  input  logic                   ls_signed,
  input  logic [XLEN-1:0]        ls_payload,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ack,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [XLEN-1:0]        wb_value,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic                   ls_misaligned
);

  e_lsu_state      state_q, state_d;
  logic            accept, is_mem, misaligned;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [1:0]      off_q;
  e_memsz          size_q;
  logic            signed_q;

  mr_lsu_lanes u_lanes (
    .st_off     (ls_dest[1:0]),
    .st_size    (ls_size),
    .st_payload (ls_payload),
    .st_wstrb   (st_wstrb),
    .st_wdata   (st_wdata),
    .misaligned (misaligned),
    .ld_off     (off_q),
    .ld_size    (size_q),
    .ld_signed  (signed_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  assign is_mem   = (ls_memop == MEMOP_LOAD) || (ls_memop == MEMOP_STORE);
  assign accept   = ls_valid & ls_ready;
  // Decoded from state so an async reset drops the request without a clock.
  assign mem_req  = (state_q == S_MEM);
  assign wb_valid = (state_q == S_WB);

  always_comb begin
    state_d  = state_q;
    ls_ready = 1'b0;
    case (state_q)
      S_IDLE: ls_ready = 1'b1;
      S_WB:   ls_ready = wb_ready;
      default: ls_ready = 1'b0;
    endcase
    case (state_q)
      S_MEM: if (mem_ack) state_d = mem_we ? S_IDLE : S_WB;
      default: begin
        if (accept) begin
          if (!is_mem)        state_d = S_WB;
          else if (misaligned) state_d = S_IDLE;
          else                 state_d = S_MEM;
        end else if (state_q == S_WB && wb_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      wb_value      <= '0;
      wb_reg        <= '0;
      ls_misaligned <= 1'b0;
      off_q         <= '0;
      size_q        <= MEMSZ_B;
      signed_q      <= 1'b0;
    end else begin
      ls_misaligned <= 1'b0;
      if (accept) begin
        if (!is_mem) begin
          wb_value <= ls_dest;
          wb_reg   <= ls_dest_reg;
        end else if (misaligned) begin
          ls_misaligned <= 1'b1;
        end else begin
          mem_we    <= (ls_memop == MEMOP_STORE);
          mem_addr  <= {ls_dest[XLEN-1:2], 2'b00};
          mem_wdata <= st_wdata;
          mem_wstrb <= st_wstrb;
          wb_reg    <= ls_dest_reg;
          off_q     <= ls_dest[1:0];
          size_q    <= ls_size;
          signed_q  <= ls_signed;
        end
      end
      if (state_q == S_MEM && mem_ack && !mem_we) wb_value <= ld_data;
    end
  end

endmodule

// File: tb/tb_mr_lsu.sv
// Directed bench for mr_lsu: inputs driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_mr_lsu;
  import mr_lsu_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ls_valid, ls_ready;
  logic [XLEN-1:0]        ls_dest, ls_payload;
  logic [REGSEL_BITS-1:0] ls_dest_reg;
  e_memops                ls_memop;
  e_memsz                 ls_size;
  logic                   ls_signed;
  logic                   mem_req, mem_we, mem_ack;
  logic [XLEN-1:0]        mem_addr, mem_wdata, mem_rdata;
  logic [3:0]             mem_wstrb;
  logic                   wb_valid, wb_ready;
  logic [XLEN-1:0]        wb_value;
  logic [REGSEL_BITS-1:0] wb_reg;
  logic                   ls_misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mr_lsu dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_dest(ls_dest),
    .ls_dest_reg(ls_dest_reg), .ls_memop(ls_memop), .ls_size(ls_size),
    .ls_signed(ls_signed), .ls_payload(ls_payload),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_value(wb_value),
    .wb_reg(wb_reg), .ls_misaligned(ls_misaligned)
  );

  task automatic drive_op(input e_memops op, input e_memsz sz, input logic sgn,
                          input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] pay);
    ls_valid = 1'b1; ls_memop = op; ls_size = sz; ls_signed = sgn;
    ls_dest = addr; ls_dest_reg = rd; ls_payload = pay;
  endtask

  task automatic idle_inputs();
    ls_valid = 1'b0; ls_memop = MEMOP_NONE; ls_size = MEMSZ_W; ls_signed = 1'b0;
    ls_dest = '0; ls_dest_reg = '0; ls_payload = '0;
    mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, wb_valid, ls_misaligned} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: req/we/wbv/mis=%b want 0000",
               {mem_req, mem_we, wb_valid, ls_misaligned});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 ||
        wb_value !== 32'h0 || wb_reg !== 5'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b val=%h reg=%0d want all 0",
               mem_addr, mem_wdata, mem_wstrb, wb_value, wb_reg);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ls_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ls_ready=%b want 1", ls_ready);
    end
  endtask

  task automatic test_pass_through();
    logic saw_req = 1'b0;
    drive_op(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h1234, 5'd7, 32'h0);
    @(negedge clk);
    saw_req |= mem_req;
    ls_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_value !== 32'h1234 || wb_reg !== 5'd7) begin
      errors++;
      $display("FAIL pass_wb: valid=%b value=%h reg=%0d want 1 00001234 7",
               wb_valid, wb_value, wb_reg);
    end
    @(negedge clk);
    saw_req |= mem_req;
    checks++;
    if (saw_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_noreq: saw_req=%b wb_valid=%b want 0 0", saw_req, wb_valid);
    end
  endtask

  // Load with ack on the ack_cycles-th request cycle; checks address stability.
  task automatic test_load(input string name, input e_memsz sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input int ack_cycles, input logic [31:0] exp);
    drive_op(MEMOP_LOAD, sz, sgn, addr, 5'd5, 32'h0);
    for (int i = 1; i <= ack_cycles; i++) begin
      @(negedge clk);
      ls_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || ls_ready !== 1'b0 ||
          mem_addr !== {addr[31:2], 2'b00}) begin
        errors++;
        $display("FAIL %s_req%0d: req=%b we=%b rdy=%b addr=%h want 1 0 0 %h",
                 name, i, mem_req, mem_we, ls_ready, mem_addr, {addr[31:2], 2'b00});
      end
      if (i == ack_cycles) begin mem_ack = 1'b1; mem_rdata = rdata; end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_value !== exp || wb_reg !== 5'd5 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_wb: valid=%b value=%h reg=%0d req=%b want 1 %h 5 0",
               name, wb_valid, wb_value, wb_reg, mem_req, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_store(input string name, input e_memsz sz, input logic [31:0] addr,
                            input logic [31:0] pay, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
    drive_op(MEMOP_STORE, sz, 1'b0, addr, 5'd3, pay);
    @(negedge clk);
    ls_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== exp_strb ||
        mem_wdata !== exp_wdata || mem_addr !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s_bus: req=%b we=%b strb=%b wdata=%h addr=%h want 1 1 %b %h %h",
               name, mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr,
               exp_strb, exp_wdata, {addr[31:2], 2'b00});
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: req=%b wbv=%b rdy=%b want 0 0 1",
               name, mem_req, wb_valid, ls_ready);
    end
  endtask

  task automatic test_misaligned();
    drive_op(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h105, 5'd4, 32'h0);
    @(negedge clk);
    checks++;
    if (ls_misaligned !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 ||
        ls_ready !== 1'b1) begin
      errors++;
      $display("FAIL mis_pulse: mis=%b req=%b wbv=%b rdy=%b want 1 0 0 1",
               ls_misaligned, mem_req, wb_valid, ls_ready);
    end
    drive_op(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h55, 5'd3, 32'h0);
    @(negedge clk);
    ls_valid = 1'b0;
    checks++;
    if (ls_misaligned !== 1'b0 || wb_valid !== 1'b1 || wb_value !== 32'h55 ||
        wb_reg !== 5'd3) begin
      errors++;
      $display("FAIL mis_next: mis=%b wbv=%b value=%h reg=%0d want 0 1 00000055 3",
               ls_misaligned, wb_valid, wb_value, wb_reg);
    end
    drive_op(MEMOP_STORE, MEMSZ_H, 1'b0, 32'h201, 5'd0, 32'h1);
    @(negedge clk);
    ls_valid = 1'b0;
    checks++;
    if (ls_misaligned !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_sh: mis=%b req=%b wbv=%b want 1 0 0",
               ls_misaligned, mem_req, wb_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    drive_op(MEMOP_LOAD, MEMSZ_W, 1'b1, 32'h300, 5'd6, 32'h0);
    @(negedge clk);
    drive_op(MEMOP_NONE, MEMSZ_W, 1'b0, 32'h77, 5'd9, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || ls_ready !== 1'b0 || wb_value !== 32'hDEADBEEF ||
          wb_reg !== 5'd6) begin
        errors++;
        $display("FAIL bp_hold%0d: wbv=%b rdy=%b value=%h reg=%0d want 1 0 deadbeef 6",
                 i, wb_valid, ls_ready, wb_value, wb_reg);
      end
      if (i < 3) @(negedge clk);
    end
    wb_ready = 1'b1;
    #1;
    checks++;
    if (ls_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready: ls_ready=%b want 1", ls_ready);
    end
    @(negedge clk);
    ls_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_value !== 32'h77 || wb_reg !== 5'd9) begin
      errors++;
      $display("FAIL bp_second: wbv=%b value=%h reg=%0d want 1 00000077 9",
               wb_valid, wb_value, wb_reg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    drive_op(MEMOP_LOAD, MEMSZ_W, 1'b0, 32'h400, 5'd2, 32'h0);
    @(negedge clk);
    ls_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_req: mem_req=%b want 1", mem_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: mem_req=%b want 0", mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ls_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: rdy=%b req=%b wbv=%b want 1 0 0",
               ls_ready, mem_req, wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load("lb",  MEMSZ_B, 1'b1, 32'h103, 32'h80FFFFFF, 3, 32'hFFFFFF80);
    test_load("lbu", MEMSZ_B, 1'b0, 32'h103, 32'h80FFFFFF, 3, 32'h00000080);
    test_load("lh",  MEMSZ_H, 1'b1, 32'h402, 32'h80011234, 1, 32'hFFFF8001);
    test_load("lhu", MEMSZ_H, 1'b0, 32'h402, 32'h80011234, 1, 32'h00008001);
    test_load("lw",  MEMSZ_W, 1'b1, 32'h408, 32'h89ABCDEF, 2, 32'h89ABCDEF);
    test_store("sh", MEMSZ_H, 32'h202, 32'hAAAABEEF, 4'b1100, 32'hBEEFBEEF);
    test_store("sb", MEMSZ_B, 32'h001, 32'h00000012, 4'b0010, 32'h12121212);
    test_store("sw", MEMSZ_W, 32'h10C, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mr_lsu.md
Name: mr_lsu

Overview:
- Load/store stage of the mr-soc integer pipeline, fed by the execute stage.
- Consumes the execute-to-LS interface: ls_valid/ls_ready, ALU result or effective address, dest reg, memop, size, signedness, store payload.
- Performs one data-memory access per load or store over a simple req/ack bus, aligns and extends load data, and presents results to writeback.
- Non-memory ops pass through to writeback.

Parameters:
- XLEN, 32, datapath width (design supports 32 only).
- REGSEL_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ls_valid  in  1  execute stage has an op
- ls_ready  out  1  LSU can accept an op this cycle
- ls_dest  in  XLEN  ALU result; effective address for loads and stores
- ls_dest_reg  in  REGSEL_BITS  destination register
- ls_memop  in  e_memops  MEMOP_NONE / MEMOP_LOAD / MEMOP_STORE
- ls_size  in  e_memsz  MEMSZ_B / MEMSZ_H / MEMSZ_W
- ls_signed  in  1  sign-extend load data
- ls_payload  in  XLEN  store data, low bits significant
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  word address, bits [1:0] forced to 0
- mem_wdata  out  XLEN  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  access complete; mem_rdata valid this cycle for loads
- mem_rdata  in  XLEN  read word
- wb_valid  out  1  writeback result valid
- wb_ready  in  1  writeback accepts
- wb_value  out  XLEN  result value
- wb_reg  out  REGSEL_BITS  result register
- ls_misaligned  out  1  one-cycle pulse: access dropped for misalignment

Behaviour:
- Reset (async): state = S_IDLE. mem_req, mem_we, wb_valid and ls_misaligned = 0. mem_addr, mem_wdata, mem_wstrb, wb_value and wb_reg = 0.
- Reset mid-access: mem_req drops immediately; the memory side must tolerate an abandoned request.
- States are S_IDLE, S_MEM and S_WB.
- ls_ready is 1 in S_IDLE, equals wb_ready in S_WB, and is 0 in S_MEM. An op is accepted when ls_valid & ls_ready.
- Accept rules, applied in S_IDLE and in S_WB on wb_ready:
  - MEMOP_NONE: wb_value <= ls_dest, wb_reg <= ls_dest_reg, next state S_WB (one-cycle latency).
  - Misaligned access (H with addr[0]=1; W with addr[1:0]!=0): no bus access, no writeback, ls_misaligned = 1 for the next cycle, next state S_IDLE.
  - Aligned load or store: latch address, size, signedness, register and payload; next state S_MEM. mem_req is asserted from the following cycle.
- S_MEM:
  - mem_req = 1. mem_addr, mem_we, mem_wdata and mem_wstrb are stable until mem_ack.
  - mem_ack on a load: capture the extended data into wb_value, next state S_WB.
  - mem_ack on a store: next state S_IDLE; a store produces no writeback.
  - mem_ack in the first req cycle is legal; minimum load latency, accept to wb_valid, is 2 cycles.
- S_WB:
  - wb_valid = 1; wb_value and wb_reg are held while wb_ready = 0.
  - On wb_ready: accept a new op if ls_valid, else go to S_IDLE.
- Store lane steering, with o = addr[1:0]:
  - B: wstrb = 0001 << o; wdata = payload[7:0] replicated ×4.
  - H: wstrb = 0011 << o; wdata = payload[15:0] replicated ×2.
  - W: wstrb = 1111; wdata = payload.
- Load extraction: shifted = mem_rdata >> (8*o).
  - B: bits [7:0], zero- or sign-extended per ls_signed.
  - H: bits [15:0], zero- or sign-extended per ls_signed.
  - W: all 32 bits; ls_signed is ignored.
- Loads to register 0 still perform the bus access and writeback; writeback discards the result.
- ls_misaligned and wb_valid are never high in the same cycle.

Decomposition:
- Shared package: e_memops and e_memsz enums, XLEN and REGSEL_BITS constants, and the LSU state enum.
- Sub-module mr_lsu_lanes (purely combinational): store strobe and data replication, load shift and extend, misalignment detect.
- The FSM and registers stay in mr_lsu.

Test Plan:
- Pass-through: MEMOP_NONE, ls_dest=0x1234, reg 7, wb_ready=1 -> next cycle wb_valid=1, wb_value=0x1234, wb_reg=7; mem_req never asserted.
- Signed byte load: addr 0x103, LB signed, mem_rdata=0x80FFFFFF, ack after 3 req cycles:
  - mem_addr=0x100 held stable over those 3 cycles;
  - then wb_value=0xFFFFFF80.
  - The same case as LBU gives 0x00000080.
- Half store: SH to 0x202, payload 0xAAAABEEF -> mem_we=1, wstrb=1100, wdata=0xBEEFBEEF, no wb_valid, ls_ready back to 1 the cycle after ack.
- Misaligned load: LW at 0x105 -> ls_misaligned pulses 1 cycle, mem_req stays 0, wb_valid stays 0, next op accepted the following cycle.
- Backpressure: load completes with wb_ready=0 for 4 cycles and a second op waiting:
  - ls_ready=0 and wb_value stable for those 4 cycles;
  - the second op is accepted in the same cycle wb_ready rises.
- Async reset asserted during S_MEM -> mem_req falls without a clock edge; after release, state S_IDLE and ls_ready=1.
